// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: optional level synchroniser, per-channel Mealy and Moore
// edge ticks with rise/fall selection, and a saturating edge counter with a sticky flag.
module edge_detector_multi #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH-1:0]         level,
   input  logic [2*CH-1:0]       mode,
   input  logic [CH-1:0]         clr,
   output logic [CH-1:0]         mealy_tick,
   output logic [CH-1:0]         moore_tick,
   output logic [CH-1:0]         sticky,
   output logic [CH*CNT_W-1:0]   edge_cnt
);

   typedef enum logic [1:0] {ZERO, RISE, ONE, FALL} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic             s;
      logic             p;
      state_t           state;
      state_t           state_nxt;
      logic             sticky_q;
      logic [CNT_W-1:0] cnt_q;

      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = level[i];
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[SYNC_STAGES-2:0], level[i]};
         end
         assign s = sync_q[SYNC_STAGES-1];
      end

      // previous-sample register and Moore state
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            p     <= 1'b0;
            state <= ZERO;
         end else begin
            p     <= s;
            state <= state_nxt;
         end
      end

      // FSM tracks s regardless of mode so a mode change never produces a late tick
      always_comb begin
         state_nxt = state;
         case (state)
            ZERO:    if (s)  state_nxt = RISE;
            RISE:    state_nxt = s ? ONE : FALL;
            ONE:     if (!s) state_nxt = FALL;
            FALL:    state_nxt = s ? RISE : ZERO;
            default: state_nxt = ZERO;
         endcase
      end

      assign mealy_tick[i] = (s & ~p & mode[2*i]) | (~s & p & mode[2*i+1]);
      assign moore_tick[i] = ((state == RISE) & mode[2*i]) | ((state == FALL) & mode[2*i+1]);

      // clear takes priority over a coincident tick
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
         end else if (clr[i]) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
         end else if (moore_tick[i]) begin
            cnt_q    <= sat_inc(cnt_q);
            sticky_q <= 1'b1;
         end
      end

      assign sticky[i]                  = sticky_q;
      assign edge_cnt[CNT_W*i +: CNT_W] = cnt_q;
   end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi: default build, a 3-bit counter build and a
// build without synchroniser, all driven from the same clock, reset and inputs.
module tb_edge_detector_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  level = '0;
   logic [7:0]  mode = '0;
   logic [3:0]  clr = '0;

   logic [3:0]  d_mealy, d_moore, d_sticky;
   logic [31:0] d_cnt;
   logic [3:0]  s_mealy, s_moore, s_sticky;
   logic [11:0] s_cnt;
   logic [3:0]  n_mealy, n_moore, n_sticky;
   logic [31:0] n_cnt;

   int n_vec  = 0;
   int n_fail = 0;
   int m_cnt [4];
   int o_cnt [4];
   int exp_c [4];

   typedef struct {
      logic [3:0]  lv;
      logic [3:0]  cl;
      logic [3:0]  mealy;
      logic [3:0]  moore;
      logic [3:0]  stk;
      logic [31:0] cnt;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;

   edge_detector_multi #(.CH(4), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
      .mealy_tick(d_mealy), .moore_tick(d_moore), .sticky(d_sticky), .edge_cnt(d_cnt));

   edge_detector_multi #(.CH(4), .SYNC_STAGES(2), .CNT_W(3)) u_sat (
      .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
      .mealy_tick(s_mealy), .moore_tick(s_moore), .sticky(s_sticky), .edge_cnt(s_cnt));

   edge_detector_multi #(.CH(4), .SYNC_STAGES(0), .CNT_W(8)) u_ns (
      .clk(clk), .rst(rst), .level(level), .mode(mode), .clr(clr),
      .mealy_tick(n_mealy), .moore_tick(n_moore), .sticky(n_sticky), .edge_cnt(n_cnt));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_tallies();
      for (int c = 0; c < 4; c++) begin
         m_cnt[c] = 0;
         o_cnt[c] = 0;
      end
   endtask

   // one clock cycle: drive, sample u_dut ticks at the falling edge, return just after the rising edge
   task automatic run_cycle(input logic [3:0] lv, input logic [3:0] cl);
      level = lv;
      clr   = cl;
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         if (d_mealy[c]) m_cnt[c]++;
         if (d_moore[c]) o_cnt[c]++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] lv;
      logic [3:0] prev;

      tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000};
      tbl[1] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000};
      tbl[2] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0000};
      tbl[3] = '{4'b0001, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 32'h0000_0000};
      tbl[4] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 32'h0000_0001};
      tbl[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 32'h0000_0101};
      tbl[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 32'h0000_0201};
      tbl[7] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 32'h0000_0201};
      tbl[8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 32'h0000_0201};
      tbl[9] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 32'h0000_0200};

      // reset with ch0=rise, ch1=both, ch2=fall, ch3=rise
      mode = 8'h6D;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mealy",  {28'd0, d_mealy},  32'd0);
      check("rst_moore",  {28'd0, d_moore},  32'd0);
      check("rst_sticky", {28'd0, d_sticky}, 32'd0);
      check("rst_cnt",    d_cnt,             32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int j = 0; j < 10; j++) begin
         level = tbl[j].lv;
         clr   = tbl[j].cl;
         @(negedge clk);
         check($sformatf("tbl%0d_mealy", j),  {28'd0, d_mealy},  {28'd0, tbl[j].mealy});
         check($sformatf("tbl%0d_moore", j),  {28'd0, d_moore},  {28'd0, tbl[j].moore});
         check($sformatf("tbl%0d_sticky", j), {28'd0, d_sticky}, {28'd0, tbl[j].stk});
         check($sformatf("tbl%0d_cnt", j),    d_cnt,             tbl[j].cnt);
         @(posedge clk);
         #1;
      end
      clr = '0;

      // ch2 falling-only: 5 full toggles
      clear_tallies();
      for (int t = 0; t < 5; t++) begin
         repeat (3) run_cycle(4'b0101, 4'b0000);
         repeat (3) run_cycle(4'b0001, 4'b0000);
      end
      repeat (5) run_cycle(4'b0001, 4'b0000);
      check("fall_mealy_ticks", m_cnt[2], 5);
      check("fall_moore_ticks", o_cnt[2], 5);
      check("fall_cnt2", {24'd0, d_cnt[23:16]}, 32'd5);
      check("fall_sticky2", {31'd0, d_sticky[2]}, 32'd1);

      // ch2 mode 00: FSM keeps tracking but nothing is reported
      mode = 8'h4D;
      clear_tallies();
      for (int t = 0; t < 5; t++) begin
         repeat (3) run_cycle(4'b0101, 4'b0000);
         repeat (3) run_cycle(4'b0001, 4'b0000);
      end
      repeat (5) run_cycle(4'b0001, 4'b0000);
      check("off_mealy_ticks", m_cnt[2], 0);
      check("off_moore_ticks", o_cnt[2], 0);
      check("off_cnt2", {24'd0, d_cnt[23:16]}, 32'd5);

      // ch3 rising: 10 edges saturate the 3-bit counter at 7
      for (int t = 0; t < 10; t++) begin
         repeat (2) run_cycle(4'b1001, 4'b0000);
         repeat (2) run_cycle(4'b0001, 4'b0000);
      end
      repeat (4) run_cycle(4'b0001, 4'b0000);
      check("sat_cnt3", {29'd0, s_cnt[11:9]}, 32'd7);
      check("sat_sticky3", {31'd0, s_sticky[3]}, 32'd1);
      check("wide_cnt3", {24'd0, d_cnt[31:24]}, 32'd10);

      // clear coincident with a Moore tick wins
      repeat (3) run_cycle(4'b1001, 4'b0000);
      level = 4'b1001;
      clr   = 4'b1000;
      @(negedge clk);
      check("clr_tick_moore3", {31'd0, s_moore[3]}, 32'd1);
      @(posedge clk);
      #1;
      clr = '0;
      @(negedge clk);
      check("clr_cnt3", {29'd0, s_cnt[11:9]}, 32'd0);
      check("clr_sticky3", {31'd0, s_sticky[3]}, 32'd0);
      check("clr_moore3_done", {31'd0, s_moore[3]}, 32'd0);
      @(posedge clk);
      #1;

      // level held high through reset: exactly one rise per channel
      mode  = 8'h55;
      level = 4'b1111;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst2_mealy", {28'd0, d_mealy}, 32'd0);
      check("rst2_cnt", d_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_tallies();
      repeat (8) run_cycle(4'b1111, 4'b0000);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("hold_mealy_ch%0d", c), m_cnt[c], 1);
         check($sformatf("hold_moore_ch%0d", c), o_cnt[c], 1);
      end
      check("hold_cnt", d_cnt, 32'h0101_0101);
      check("hold_sticky", {28'd0, d_sticky}, 32'h0000_000F);

      // reset mid-tick truncates everything without a clock
      repeat (6) run_cycle(4'b0000, 4'b0000);
      level = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_moore", {28'd0, d_moore}, 32'h0000_000F);
      check("pre_rst_cnt", d_cnt, 32'h0101_0101);
      #2;
      rst = 1'b1;
      #1;
      check("async_moore", {28'd0, d_moore}, 32'd0);
      check("async_cnt", d_cnt, 32'd0);
      check("async_sticky", {28'd0, d_sticky}, 32'd0);

      // no-synchroniser build
      level = 4'b0000;
      mode  = 8'hFF;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) run_cycle(4'b0000, 4'b0000);
      level = 4'b1111;
      #1;
      check("ns_mealy_same_cycle", {28'd0, n_mealy}, 32'h0000_000F);
      check("sync_mealy_not_yet", {28'd0, d_mealy}, 32'd0);
      @(posedge clk);
      #1;
      check("ns_moore_next", {28'd0, n_moore}, 32'h0000_000F);
      check("ns_mealy_gone", {28'd0, n_mealy}, 32'd0);
      repeat (5) run_cycle(4'b1111, 4'b0000);
      check("ns_cnt_one", n_cnt, 32'h0101_0101);
      run_cycle(4'b1111, 4'b1111);

      // simultaneous, independent edges on all channels
      prev = 4'b1111;
      for (int c = 0; c < 4; c++) exp_c[c] = 0;
      for (int k = 0; k < 12; k++) begin
         lv = {1'b1, 1'(((k / 3) % 2) == 1), 1'(((k / 2) % 2) == 1), 1'((k % 2) == 1)};
         for (int c = 0; c < 4; c++) if (lv[c] != prev[c]) exp_c[c]++;
         prev = lv;
         run_cycle(lv, 4'b0000);
      end
      repeat (5) run_cycle(prev, 4'b0000);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("ns_multi_cnt_ch%0d", c), {24'd0, n_cnt[8*c +: 8]}, exp_c[c]);
         check($sformatf("sync_multi_cnt_ch%0d", c), {24'd0, d_cnt[8*c +: 8]}, exp_c[c]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
Parametrised multi-channel edge detector, successor to the single-channel edgeDetector.
- Each channel passes its level input through an optional synchroniser.
- Each channel detects rising, falling or both edges, selected per channel, and emits both a Mealy tick and a Moore tick.
- Each channel keeps a saturating edge counter and a sticky event flag, both clearable by the consumer.
- Used as the front-end for asynchronous pushbuttons and status lines feeding control FSMs.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (0 = level used directly; otherwise >=2)
CNT_W, 8, width of each per-channel edge counter (>=1)

Ports:
clk  input  1  system clock, all flops rising-edge
rst  input  1  asynchronous, active-high reset
level  input  CH  raw level per channel
mode  input  2*CH  per-channel edge select, bits [2i+1:2i]: bit0 = rising enable, bit1 = falling enable
clr  input  CH  synchronous clear of channel i counter and sticky flag
mealy_tick  output  CH  combinational edge tick
moore_tick  output  CH  registered-state edge tick
sticky  output  CH  set on any qualified Moore tick, held until clr
edge_cnt  output  CH*CNT_W  per-channel count of qualified Moore ticks, channel i at [CNT_W*i +: CNT_W]

Behaviour:
- Reset (async assert, released synchronously by the environment) clears everything:
  - synchroniser flops = 0, prev register p = 0, FSM = ZERO;
  - sticky = 0, edge_cnt = 0, moore_tick = 0;
  - mealy_tick = 0 while s = 0.
- s[i] is the last synchroniser flop, or level[i] when SYNC_STAGES = 0. p[i] is s[i] registered every cycle.
- Mealy: mealy_tick[i] = (s & ~p & mode[2i]) | (~s & p & mode[2i+1]).
  - Combinational from s, so it asserts in the same cycle s changes.
  - It lasts exactly one cycle per edge.
- Moore FSM, per channel, 2-bit state, always tracks s regardless of mode:
  - ZERO: s=1 -> RISE, else stay ZERO.
  - RISE: s=1 -> ONE, s=0 -> FALL.
  - ONE: s=0 -> FALL, else stay ONE.
  - FALL: s=0 -> ZERO, s=1 -> RISE.
- moore_tick[i] = (state==RISE & mode[2i]) | (state==FALL & mode[2i+1]). It is decoded from state only and is glitch-free.
- Latency:
  - an edge on level is seen on s after SYNC_STAGES clocks;
  - mealy_tick asserts in that cycle;
  - moore_tick asserts one clock later, for one cycle.
- A one-cycle pulse on s (0-1-0) gives a rise tick then a fall tick on consecutive cycles on both outputs, subject to mode.
- mode = 00 suppresses both ticks; the FSM and p keep tracking.
- A mode change affects the outputs immediately. No history is kept, so a tick is never emitted late.
- Counter and sticky update on each clock edge:
  - clr[i] = 1: edge_cnt = 0, sticky = 0. Clear wins over a same-cycle moore_tick.
  - else if moore_tick[i]: edge_cnt increments, saturating at 2^CNT_W-1 (never wraps), and sticky = 1.
- Channels are fully independent, including simultaneous edges on all channels.
- Level held high through reset release: s rises after SYNC_STAGES clocks and a rise edge is reported. This is intended.
- Reset asserted mid-operation: all state clears immediately. A tick in progress is truncated.

Test Plan:
1. Reset, then ch0 mode=01, level[0] 0->1 at a clk edge.
   - mealy_tick[0] high 2 clocks later for 1 cycle, moore_tick[0] high 1 cycle after that.
   - edge_cnt[0]=1, sticky[0]=1.
2. ch1 mode=11, level[1] 1-cycle-wide high pulse.
   - mealy_tick[1] pulses twice on consecutive cycles, as does moore_tick[1].
   - edge_cnt[1]=2.
3. ch2 mode=10, 5 full level toggles (5 rises, 5 falls).
   - Only 5 falling ticks, edge_cnt[2]=5.
   - mode=00 then 5 more toggles: no ticks, count stays 5.
4. CNT_W=3 build, ch3 mode=01, 10 rising edges.
   - edge_cnt[3] reaches 7 and holds 7, no wrap.
   - clr[3] coincident with a moore_tick: next value 0, sticky[3]=0.
5. level=4'b1111 held while rst asserted then released.
   - All four channels report exactly one rise (mode=01).
   - Assert rst while moore_tick high: tick, counts and sticky drop to 0 without waiting for clk.
6. SYNC_STAGES=0 build: mealy_tick follows level combinationally in the same cycle.
   - Moore tick 1 clock later.
   - All channels edging simultaneously produce independent, correct counts.
